// File: rtl/hilo_mdu.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Optional macro HILO_MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    logic [4:0]         count;
    logic [WIDTH-1:0]   operand;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;         // {partial product | remainder, multiplier | quotient}
    logic               is_div;
    logic               neg_result;
    logic               neg_rem;

    logic               is_signed;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sign_a    = is_signed & rs_data[WIDTH-1];
    assign sign_b    = is_signed & rt_data[WIDTH-1];
    assign mag_a     = sign_a ? -rs_data : rs_data;
    assign mag_b     = sign_b ? -rt_data : rt_data;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    assign mul_next  = {mul_sum, acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder may need WIDTH+1 bits before the compare.
    assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, operand};
    assign div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef HILO_MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (!is_div) begin
            if (neg_result) {fix_hi, fix_lo} = -acc;
        end else begin
            if (neg_result) fix_lo = -acc[WIDTH-1:0];
            if (neg_rem)    fix_hi = -acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            count      <= '0;
            operand    <= '0;
            acc        <= '0;
            is_div     <= 1'b0;
            neg_result <= 1'b0;
            neg_rem    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                    is_div     <= op[1];
                                    // Divide by zero keeps the quotient positive so it reads all ones;
                                    // the remainder path then reproduces rs_data unchanged.
                                    neg_result <= (sign_a ^ sign_b) & (|rt_data);
                                    neg_rem    <= sign_a;
                                    operand    <= op[1] ? mag_b : mag_a;
                                    acc        <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                                    count      <= 5'd31;
                                    state      <= CALC;
                                    busy       <= 1'b1;
`ifdef HILO_MDU_FAST_MUL_EN
                                    if (!op[1]) begin
                                        acc   <= fast_prod;
                                        state <= FIX;
                                    end
`endif
                                end
                                OP_MTHI: hi <= rs_data;
                                OP_MTLO: lo <= rs_data;
                                default: ;
                            endcase
                        end
                    end
                    CALC: begin
                        acc <= is_div ? div_next : mul_next;
                        if (count == 5'd0) state <= FIX;
                        else               count <= count - 5'd1;
                    end
                    FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: directed plan cases, flush/reset aborts and random ops
// checked against an arithmetic reference model.
module tb_hilo_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    always #5 clk = ~clk;

    hilo_mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: {HI, LO} from plain signed/unsigned arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        case (o)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp;
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                return up;
            end
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Drives the issue cycle; returns at the negedge of cycle E0+1.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < 200) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        int          bcnt;
        int          exp_lat;
        int          exp_busy;
        logic [63:0] m;
        m        = model(o, a, b);
        exp_lat  = 34;
        exp_busy = 33;
`ifdef HILO_MDU_FAST_MUL_EN
        if (o < 3'd2) begin
            exp_lat  = 2;
            exp_busy = 1;
        end
`endif
        issue(o, a, b);
        wait_done(lat, bcnt);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bcnt, exp_busy);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        exp_hi = m[63:32];
        exp_lo = m[31:0];
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] o, input logic [31:0] a);
        issue(o, a, 32'd0);
        if (o == 3'd4) exp_hi = a;
        else           exp_lo = a;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        check({tag, "_no_done"}, pulses, 32'd0);
        check({tag, "_hi_kept"}, hi, exp_hi);
        check({tag, "_lo_kept"}, lo, exp_lo);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          bcnt;
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd6; rs_data = '0; rt_data = '0;
        repeat (2) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);

        run_md("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi_const", hi, 32'hFFFFFFFE);
        check("multu_max_lo_const", lo, 32'h00000001);
        run_md("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'h00000007);
        check("mult_neg3x7_lo_const", lo, 32'hFFFFFFEB);
        run_md("div_neg7d2", 3'd2, 32'hFFFFFFF9, 32'h00000002);
        check("div_neg7d2_lo_const", lo, 32'hFFFFFFFD);
        run_md("divu_by0", 3'd3, 32'h00001234, 32'h00000000);
        check("divu_by0_lo_const", lo, 32'hFFFFFFFF);
        run_md("div_by0_neg", 3'd2, 32'h80000005, 32'h00000000);
        run_md("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_md("multu_3x5", 3'd1, 32'd3, 32'd5);

        // MTHI then DIVU 100/7 with an ignored MTLO re-pulse at cycle 10.
        run_mt("mthi", 3'd4, 32'hA5A5A5A5);
        issue(3'd3, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 3'd5; rs_data = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        check("repulse_lo_kept", lo, exp_lo);
        check("repulse_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bcnt);
        check("repulse_latency", lat + 10, 32'd34);
        check("divu_100_7_lo", lo, 32'd14);
        check("divu_100_7_hi", hi, 32'd2);
        exp_hi = 32'd2;
        exp_lo = 32'd14;

        // Flush at cycle 20 of a multiply (divide when multiply is single-cycle).
`ifdef HILO_MDU_FAST_MUL_EN
        issue(3'd2, 32'h12345678, 32'h00000321);
`else
        issue(3'd0, 32'h12345678, 32'hFEDCBA98);
`endif
        repeat (19) @(negedge clk);
        check("flush20_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush20_busy_after", {31'd0, busy}, 32'd0);
        watch_no_done("flush20", 40);

        // Flush in the FIX cycle.
        issue(3'd3, 32'd1000, 32'd3);
        repeat (32) @(negedge clk);
        check("flushfix_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flushfix_busy_after", {31'd0, busy}, 32'd0);
        watch_no_done("flushfix", 5);

        // Flush together with start in IDLE.
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_data = 32'h12345678; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 3'd6; flush = 1'b0;
        check("flush_idle_busy", {31'd0, busy}, 32'd0);
        watch_no_done("flush_idle", 3);

        // Random operations against the model.
        for (int i = 0; i < 24; i++) begin
            o   = 3'($urandom_range(0, 5));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (o >= 3'd4) run_mt($sformatf("rand%0d_mt", i), o, a);
            else           run_md($sformatf("rand%0d_op%0d", i, o), o, a, b);
        end

        // Reset at cycle 5 of a multiply.
        run_mt("pre_reset_mtlo", 3'd5, 32'h0BADF00D);
        issue(3'd0, 32'h00000FFF, 32'h00000FFF);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        check("midreset_hi", hi, exp_hi);
        check("midreset_lo", lo, exp_lo);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        watch_no_done("midreset", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
